pc_call_stack: RTL and testbench
================================

# pc_call_stack

Program counter and hardware return stack for the MiniRISC CPU. Sits directly downstream of the controller state machine: it consumes the fetch, jump, call, return and interrupt strobes and produces the instruction address. It also holds the saved return context: PC, ALU flags, IE and IF. On return-from-interrupt it supplies the restored IE/IF values back to the controller in the same cycle.

## Interface
- `PC_WIDTH`, default 8: width of the program counter / instruction address.
- `STACK_DEPTH`, default 16: number of return-stack entries; power of two, at least 2.
- `RESET_PC`, default 0x00: PC value after reset/initialize.
- `INT_VECTOR`, default 0x01: PC loaded on interrupt entry.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `initialize`  in  1  synchronous re-init strobe from the controller.
- `fetch`  in  1  instruction fetched this cycle; PC advances.
- `ex_jump`  in  1  jump taken; load `jump_addr`.
- `ex_call`  in  1  subroutine call; push context, load `jump_addr`.
- `ex_ret_sub`  in  1  return from subroutine; pop, restore PC only.
- `ex_ret_int`  in  1  return from interrupt; pop, restore PC, flags, IE, IF.
- `interrupt`  in  1  interrupt entry; push context, load `INT_VECTOR`.
- `jump_addr`  in  `PC_WIDTH`  target address from the instruction/register field.
- `flags_in`  in  4  current ALU flags, bit order {Z,C,N,V}.
- `flag_ie`, `flag_if`  in  1 each  current IE/IF from the controller.
- `dbg_pc_wr`  in  1  debug PC write; honoured only while `dbg_is_brk` is high.
- `dbg_is_brk`  in  1  controller in break state.
- `dbg_pc_din`  in  `PC_WIDTH`  debug PC value.
- `pc`  out  `PC_WIDTH`  registered program counter.
- `stack_flags`  out  4  flags at top of stack, combinational.
- `stack_ie`  out  1  IE at top of stack, combinational; drives the controller's `flag_ie_din`.
- `stack_if`  out  1  IF at top of stack, combinational; drives the controller's `flag_if_din`.
- `flags_restore`  out  1  equals `ex_ret_int`; ALU loads `stack_flags` on it.
- `stack_empty`  out  1  stack pointer = 0.
- `stack_full`  out  1  stack pointer = `STACK_DEPTH`.
- `stack_err`  out  1  sticky overflow/underflow indicator.

## Operation
**Entry format.** Each entry is {PC, Z, C, N, V, IE, IF}, `PC_WIDTH`+6 bits. `sp` counts occupied entries, 0..`STACK_DEPTH`. Top of stack is entry `sp`−1.

**Per-cycle action.** One action per cycle, in this priority order:
- `initialize`: `pc`=`RESET_PC`, `sp`=0, `stack_err`=0.
- `interrupt`: push {`pc`, `flags_in`, `flag_ie`, `flag_if`}; `pc`=`INT_VECTOR`.
- `ex_ret_int`: `pc`=top.PC; `sp`−1.
- `ex_ret_sub`: `pc`=top.PC; `sp`−1.
- `ex_call`: push {`pc`, `flags_in`, `flag_ie`, `flag_if`}; `pc`=`jump_addr`.
- `ex_jump`: `pc`=`jump_addr`.
- `dbg_pc_wr` with `dbg_is_brk`: `pc`=`dbg_pc_din`.
- `fetch`: `pc`=`pc`+1, wrapping modulo 2^`PC_WIDTH`.
- Otherwise: hold.

**Pushed PC.** The pushed PC is the already-incremented `pc`, i.e. the return address.

**Overflow.** A push with `stack_full`=1 is dropped: the entry is not written and `sp` is unchanged. `stack_err` is set. The PC load still happens.

**Underflow.** A pop with `stack_empty`=1 leaves `sp` at 0 and sets `stack_err`. `pc` loads 0, and `stack_flags`, `stack_ie` and `stack_if` read 0.

**Sticky error.** `stack_err` clears only on `rst` or `initialize`.

**Top-of-stack outputs.** `stack_*` outputs reflect the current top combinationally, so they are valid in the same cycle as `ex_ret_int`.

## Timing
- Reset values: `pc`=`RESET_PC`, `sp`=0, `stack_err`=0, `stack_empty`=1, `stack_full`=0. Stack contents are not reset.
- Every strobe takes effect at the next rising edge; latency is 1 cycle to `pc`.
- Read of the top of stack is combinational from the storage array (distributed RAM/registers). The write is synchronous.
- Simultaneous strobes are resolved by the priority list above. The controller normally guarantees at most one strobe per cycle.
- `rst` asserted mid-operation immediately forces the reset values. No partial push survives.

## Structure
- Shared package/header `pc_stack_defs.vh`: flag bit indices (Z=3, C=2, N=1, V=0) and the entry field offsets.
- One natural sub-module, `lifo_stack`: parameterised width/depth, with push, pop, top, empty, full and error outputs.
- The PC register and priority mux stay in the top module.

## Test plan
- **Reset/fetch:** after reset, `pc`=0x00; pulse `fetch` 3 times → `pc`=0x03. From `pc`=0xFF, one `fetch` → 0x00.
- **Call/return:** at `pc`=0x10, `ex_call` with `jump_addr`=0x40 → `pc`=0x40, `sp`=1; then `ex_ret_sub` → `pc`=0x10, `sp`=0.
- **Interrupt/RTI:** at `pc`=0x22, `flags_in`=0b1010, IE=1, IF=0, pulse `interrupt` → `pc`=0x01. Then with `ex_ret_int` high: same cycle `stack_flags`=0b1010, `stack_ie`=1, `stack_if`=0, `flags_restore`=1; next edge `pc`=0x22.
- **Overflow:** 17 calls with depth 16 → `stack_full`=1 after the 16th; the 17th sets `stack_err`, `sp` stays 16, and `pc` still loads the target.
- **Underflow:** `ex_ret_sub` with `sp`=0 → `pc`=0x00, `stack_err`=1; then `initialize` → `stack_err`=0.
- **Debug write/priority:** `dbg_pc_wr` with `dbg_is_brk`=0 → ignored. With `dbg_is_brk`=1 and `dbg_pc_din`=0x55 → `pc`=0x55. `ex_jump` and `fetch` together → jump wins.

Source files
------------

// File: rtl/pc_call_stack_pkg.sv
`default_nettype none
// ============================================================================
//  pc_call_stack_pkg
//  Return-stack entry layout, flag bit indices and the PC action encoding.
//  Revision: 1.0
// ============================================================================
package pc_call_stack_pkg;

  // Flag positions within the 4-bit ALU flag vector {Z,C,N,V}
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  // Entry layout, LSB first: IF, IE, flags[3:0], PC
  localparam int ENT_IF        = 0;
  localparam int ENT_IE        = 1;
  localparam int ENT_FLAGS_LSB = 2;
  localparam int ENT_PC_LSB    = 6;
  localparam int ENT_CTX_W     = 6;

  function automatic int entry_width(input int pc_width);
    return pc_width + ENT_CTX_W;
  endfunction

  typedef enum logic [3:0] {
    ACT_HOLD  = 4'd0,
    ACT_INIT  = 4'd1,
    ACT_INT   = 4'd2,
    ACT_RETI  = 4'd3,
    ACT_RETS  = 4'd4,
    ACT_CALL  = 4'd5,
    ACT_JUMP  = 4'd6,
    ACT_DBG   = 4'd7,
    ACT_FETCH = 4'd8
  } action_e;

endpackage
`default_nettype wire

// File: rtl/pc_call_stack_if.sv
`default_nettype none
// ============================================================================
//  pc_call_stack_if
//  Controller <-> PC/return-stack strobes, debug access and status outputs.
//  Revision: 1.0
// ============================================================================
interface pc_call_stack_if #(
  parameter int PC_WIDTH = 8
);
  logic                initialize;
  logic                fetch;
  logic                ex_jump;
  logic                ex_call;
  logic                ex_ret_sub;
  logic                ex_ret_int;
  logic                interrupt;
  logic [PC_WIDTH-1:0] jump_addr;
  logic [3:0]          flags_in;
  logic                flag_ie;
  logic                flag_if;
  logic                dbg_pc_wr;
  logic                dbg_is_brk;
  logic [PC_WIDTH-1:0] dbg_pc_din;

  logic [PC_WIDTH-1:0] pc;
  logic [3:0]          stack_flags;
  logic                stack_ie;
  logic                stack_if;
  logic                flags_restore;
  logic                stack_empty;
  logic                stack_full;
  logic                stack_err;

  modport master (
    output initialize, fetch, ex_jump, ex_call, ex_ret_sub, ex_ret_int,
           interrupt, jump_addr, flags_in, flag_ie, flag_if,
           dbg_pc_wr, dbg_is_brk, dbg_pc_din,
    input  pc, stack_flags, stack_ie, stack_if, flags_restore,
           stack_empty, stack_full, stack_err
  );

  modport slave (
    input  initialize, fetch, ex_jump, ex_call, ex_ret_sub, ex_ret_int,
           interrupt, jump_addr, flags_in, flag_ie, flag_if,
           dbg_pc_wr, dbg_is_brk, dbg_pc_din,
    output pc, stack_flags, stack_ie, stack_if, flags_restore,
           stack_empty, stack_full, stack_err
  );
endinterface
`default_nettype wire

// File: rtl/pc_call_stack_lifo_stack.sv
`default_nettype none
// ============================================================================
//  lifo_stack
//  Register-array LIFO with combinational top read and sticky over/underflow.
//  Revision: 1.0
// ============================================================================
module lifo_stack #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clear,
  input  wire logic             push,
  input  wire logic             pop,
  input  wire logic [WIDTH-1:0] din,
  output logic      [WIDTH-1:0] top,
  output logic                  empty,
  output logic                  full,
  output logic                  err
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    sp;
  logic [AW-1:0]    top_idx;

  assign empty   = (sp == '0);
  assign full    = (sp == PW'(DEPTH));
  // When full the low bits wrap to 0, so minus one still lands on DEPTH-1
  assign top_idx = sp[AW-1:0] - AW'(1);
  assign top     = empty ? '0 : mem[top_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp  <= '0;
      err <= 1'b0;
    end else if (clear) begin
      sp  <= '0;
      err <= 1'b0;
    end else if (push) begin
      if (full) err <= 1'b1;
      else      sp  <= sp + PW'(1);
    end else if (pop) begin
      if (empty) err <= 1'b1;
      else       sp  <= sp - PW'(1);
    end
  end

  // Storage is deliberately not reset; only the pointer defines validity
  always_ff @(posedge clk) begin
    if (push && !full && !clear && !rst) begin
      mem[sp[AW-1:0]] <= din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_call_stack.sv
`default_nettype none
// ============================================================================
//  pc_call_stack
//  MiniRISC program counter with priority action mux and hardware return stack.
//  Revision: 1.0
// ============================================================================
module pc_call_stack
  import pc_call_stack_pkg::*;
#(
  parameter int                  PC_WIDTH    = 8,
  parameter int                  STACK_DEPTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [PC_WIDTH-1:0] INT_VECTOR  = PC_WIDTH'(1)
) (
  input  wire logic        clk,
  input  wire logic        rst,
  pc_call_stack_if.slave   bus
);
  localparam int ENT_W = entry_width(PC_WIDTH);

  action_e             act;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_next;
  logic [ENT_W-1:0]    push_entry;
  logic [ENT_W-1:0]    top_entry;
  logic                push;
  logic                pop;
  logic                clear;

  always_comb begin
    act = ACT_HOLD;
    if      (bus.initialize)                   act = ACT_INIT;
    else if (bus.interrupt)                    act = ACT_INT;
    else if (bus.ex_ret_int)                   act = ACT_RETI;
    else if (bus.ex_ret_sub)                   act = ACT_RETS;
    else if (bus.ex_call)                      act = ACT_CALL;
    else if (bus.ex_jump)                      act = ACT_JUMP;
    else if (bus.dbg_pc_wr && bus.dbg_is_brk)  act = ACT_DBG;
    else if (bus.fetch)                        act = ACT_FETCH;
  end

  assign clear = (act == ACT_INIT);
  assign push  = (act == ACT_INT)  || (act == ACT_CALL);
  assign pop   = (act == ACT_RETI) || (act == ACT_RETS);

  // pc_q already points past the current instruction, so it is the return address
  assign push_entry = {pc_q, bus.flags_in, bus.flag_ie, bus.flag_if};

  lifo_stack #(
    .WIDTH (ENT_W),
    .DEPTH (STACK_DEPTH)
  ) u_lifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .top   (top_entry),
    .empty (bus.stack_empty),
    .full  (bus.stack_full),
    .err   (bus.stack_err)
  );

  always_comb begin
    pc_next = pc_q;
    case (act)
      ACT_INIT:  pc_next = RESET_PC;
      ACT_INT:   pc_next = INT_VECTOR;
      ACT_RETI,
      ACT_RETS:  pc_next = top_entry[ENT_PC_LSB +: PC_WIDTH];
      ACT_CALL,
      ACT_JUMP:  pc_next = bus.jump_addr;
      ACT_DBG:   pc_next = bus.dbg_pc_din;
      ACT_FETCH: pc_next = pc_q + PC_WIDTH'(1);
      default:   pc_next = pc_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_next;
  end

  assign bus.pc            = pc_q;
  assign bus.stack_flags   = top_entry[ENT_FLAGS_LSB +: 4];
  assign bus.stack_ie      = top_entry[ENT_IE];
  assign bus.stack_if      = top_entry[ENT_IF];
  assign bus.flags_restore = bus.ex_ret_int;

endmodule
`default_nettype wire

// File: tb/tb_pc_call_stack.sv
`default_nettype none
// ============================================================================
//  tb_pc_call_stack
//  Directed scoreboard bench for the PC / return-stack block.
//  Revision: 1.0
// ============================================================================
module tb_pc_call_stack;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_call_stack_if #(.PC_WIDTH(8)) b ();

  pc_call_stack #(
    .PC_WIDTH    (8),
    .STACK_DEPTH (16),
    .RESET_PC    (8'h00),
    .INT_VECTOR  (8'h01)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  typedef struct {
    string      tag;
    logic [7:0] pc;
    logic       empty;
    logic       full;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    b.initialize = 1'b0; b.fetch      = 1'b0; b.ex_jump   = 1'b0;
    b.ex_call    = 1'b0; b.ex_ret_sub = 1'b0; b.ex_ret_int = 1'b0;
    b.interrupt  = 1'b0; b.dbg_pc_wr  = 1'b0;
  endtask

  // Expected state after the next edge is queued now and scored once the edge lands
  task automatic step(input string tag, input logic [7:0] p, input logic e,
                      input logic f, input logic er);
    exp_t x;
    x.tag = tag; x.pc = p; x.empty = e; x.full = f; x.err = er;
    sb.push_back(x);
    @(posedge clk); #1;
    x = sb.pop_front();
    chk({x.tag, "/pc"},    32'(b.pc),          32'(x.pc));
    chk({x.tag, "/empty"}, 32'(b.stack_empty), 32'(x.empty));
    chk({x.tag, "/full"},  32'(b.stack_full),  32'(x.full));
    chk({x.tag, "/err"},   32'(b.stack_err),   32'(x.err));
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    b.jump_addr = '0; b.flags_in = '0; b.flag_ie = 1'b0; b.flag_if = 1'b0;
    b.dbg_is_brk = 1'b0; b.dbg_pc_din = '0;

    #2;
    chk("reset/pc",    32'(b.pc),          32'h00);
    chk("reset/empty", 32'(b.stack_empty), 32'd1);
    chk("reset/full",  32'(b.stack_full),  32'd0);
    chk("reset/err",   32'(b.stack_err),   32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    b.fetch = 1'b1; step("fetch1", 8'h01, 1'b1, 1'b0, 1'b0);
    b.fetch = 1'b1; step("fetch2", 8'h02, 1'b1, 1'b0, 1'b0);
    b.fetch = 1'b1; step("fetch3", 8'h03, 1'b1, 1'b0, 1'b0);

    b.dbg_pc_wr = 1'b1; b.dbg_is_brk = 1'b0; b.dbg_pc_din = 8'h55;
    step("dbg_nobrk", 8'h03, 1'b1, 1'b0, 1'b0);
    b.dbg_pc_wr = 1'b1; b.dbg_is_brk = 1'b1; b.dbg_pc_din = 8'hFF;
    step("dbg_ff", 8'hFF, 1'b1, 1'b0, 1'b0);
    b.dbg_is_brk = 1'b0;
    b.fetch = 1'b1; step("wrap", 8'h00, 1'b1, 1'b0, 1'b0);
    b.dbg_pc_wr = 1'b1; b.dbg_is_brk = 1'b1; b.dbg_pc_din = 8'h55;
    step("dbg_55", 8'h55, 1'b1, 1'b0, 1'b0);
    b.dbg_is_brk = 1'b0;

    b.ex_jump = 1'b1; b.fetch = 1'b1; b.jump_addr = 8'h10;
    step("jump_vs_fetch", 8'h10, 1'b1, 1'b0, 1'b0);

    b.ex_call = 1'b1; b.jump_addr = 8'h40;
    step("call", 8'h40, 1'b0, 1'b0, 1'b0);
    b.ex_ret_sub = 1'b1;
    step("ret_sub", 8'h10, 1'b1, 1'b0, 1'b0);

    b.ex_jump = 1'b1; b.jump_addr = 8'h22;
    step("jump22", 8'h22, 1'b1, 1'b0, 1'b0);
    b.flags_in = 4'b1010; b.flag_ie = 1'b1; b.flag_if = 1'b0;
    b.interrupt = 1'b1;
    step("int", 8'h01, 1'b0, 1'b0, 1'b0);

    // Live flags change so the restored values must come from the stack
    b.flags_in = 4'b0101; b.flag_ie = 1'b0; b.flag_if = 1'b1;
    b.ex_ret_int = 1'b1; #1;
    chk("rti/stack_flags",   32'(b.stack_flags),   32'hA);
    chk("rti/stack_ie",      32'(b.stack_ie),      32'd1);
    chk("rti/stack_if",      32'(b.stack_if),      32'd0);
    chk("rti/flags_restore", 32'(b.flags_restore), 32'd1);
    step("rti", 8'h22, 1'b1, 1'b0, 1'b0);
    chk("rti/restore_drop", 32'(b.flags_restore), 32'd0);

    for (int j = 0; j < 16; j++) begin
      b.ex_call = 1'b1; b.jump_addr = 8'(8'h80 + j);
      step($sformatf("call_fill%0d", j), 8'(8'h80 + j), 1'b0, (j == 15), 1'b0);
    end
    b.ex_call = 1'b1; b.jump_addr = 8'hA0;
    step("call_ovf", 8'hA0, 1'b0, 1'b1, 1'b1);

    // Call j pushed 0x22 (j=0) or 0x7F+j; the dropped 17th must not show up
    for (int k = 0; k < 16; k++) begin
      int j;
      j = 15 - k;
      b.ex_ret_sub = 1'b1;
      step($sformatf("pop%0d", k), (j == 0) ? 8'h22 : 8'(8'h7F + j),
           (k == 15), 1'b0, 1'b1);
    end

    b.initialize = 1'b1;
    step("init", 8'h00, 1'b1, 1'b0, 1'b0);
    b.ex_jump = 1'b1; b.jump_addr = 8'h33;
    step("jump33", 8'h33, 1'b1, 1'b0, 1'b0);
    b.ex_ret_sub = 1'b1; #1;
    chk("udf/stack_flags", 32'(b.stack_flags), 32'h0);
    chk("udf/stack_ie",    32'(b.stack_ie),    32'd0);
    step("underflow", 8'h00, 1'b1, 1'b0, 1'b1);
    b.ex_jump = 1'b1; b.jump_addr = 8'h44;
    step("err_sticky", 8'h44, 1'b1, 1'b0, 1'b1);
    b.initialize = 1'b1; b.fetch = 1'b1;
    step("init_clr", 8'h00, 1'b1, 1'b0, 1'b0);

    b.interrupt = 1'b1; b.ex_call = 1'b1; b.jump_addr = 8'h77;
    step("int_vs_call", 8'h01, 1'b0, 1'b0, 1'b0);
    b.ex_call = 1'b1; b.jump_addr = 8'h60;
    step("call2", 8'h60, 1'b0, 1'b0, 1'b0);

    rst = 1'b1; #1;
    chk("midrst/pc",    32'(b.pc),          32'h00);
    chk("midrst/empty", 32'(b.stack_empty), 32'd1);
    chk("midrst/err",   32'(b.stack_err),   32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    b.fetch = 1'b1; step("post_rst", 8'h01, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
